// File: rtl/reg_access_sequencer_pkg.sv
// reg_seq_pkg: shared definitions for the register-access sequencer.
//   - opcode constants and instruction-word field positions
//   - instruction class enum and sequencer state enum
//   - opc_class(): maps an opcode to its class
package reg_seq_pkg;

  localparam int unsigned OPC_BITS = 5;
  localparam int unsigned REG_W    = 4;

  // Instruction-word field positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_LSB  = 15;

  // Opcode constants
  localparam logic [OPC_BITS-1:0] OPC_I_A  = 5'b00000;
  localparam logic [OPC_BITS-1:0] OPC_I_B  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OPC_R_LO = 5'b00011;
  localparam logic [OPC_BITS-1:0] OPC_R_HI = 5'b01010;
  localparam logic [OPC_BITS-1:0] OPC_I_LO = 5'b01011;
  localparam logic [OPC_BITS-1:0] OPC_I_HI = 5'b01101;
  localparam logic [OPC_BITS-1:0] OPC_BR   = 5'b10010;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_S,
    CLS_B,
    CLS_N
  } cls_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_B,
    ST_RD_C,
    ST_RD_A,
    ST_WAIT_RES,
    ST_WR_A,
    ST_DONE
  } state_t;

  function automatic cls_t opc_class(input logic [OPC_BITS-1:0] opc);
    if (opc >= OPC_R_LO && opc <= OPC_R_HI)
      return CLS_R;
    if (opc == OPC_I_A || opc == OPC_I_B || (opc >= OPC_I_LO && opc <= OPC_I_HI))
      return CLS_I;
    if (opc == OPC_ST)
      return CLS_S;
    if (opc == OPC_BR)
      return CLS_B;
    return CLS_N;
  endfunction

endpackage

// File: rtl/reg_access_sequencer_seq_next_state.sv
// seq_next_state: combinational next-state and next-output decode for the
// register-access sequencer. Outputs are a pure function of the next state
// and the register fields, so the top only has to register them.
// Ports:
//   i_state      current state
//   i_cls        instruction class (of the incoming IR when idle, else latched)
//   i_hold       freeze request
//   i_flush      abort request (wins over hold and start)
//   i_start      start request, honoured only in IDLE
//   i_res_valid  ALU result ready, consumed only in WAIT_RES
//   i_ra/rb/rc   register fields for the output decode
//   o_state_nxt  next state
//   o_sel, o_sel_en, o_sel_wr, o_busy, o_done  next registered output values
module seq_next_state
  import reg_seq_pkg::*;
#(
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  state_t           i_state,
  input  cls_t             i_cls,
  input  logic             i_hold,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic             i_res_valid,
  input  logic [REG_W-1:0] i_ra,
  input  logic [REG_W-1:0] i_rb,
  input  logic [REG_W-1:0] i_rc,
  output state_t           o_state_nxt,
  output logic [REG_W-1:0] o_sel,
  output logic             o_sel_en,
  output logic             o_sel_wr,
  output logic             o_busy,
  output logic             o_done
);

  always_comb begin
    o_state_nxt = i_state;
    if (i_flush) begin
      o_state_nxt = ST_IDLE;
    end else if (!i_hold) begin
      unique case (i_state)
        ST_IDLE: begin
          if (i_start) begin
            unique case (i_cls)
              CLS_R, CLS_I, CLS_S: o_state_nxt = ST_RD_B;
              CLS_B:               o_state_nxt = ST_RD_A;
              default:             o_state_nxt = ST_DONE;
            endcase
          end
        end
        ST_RD_B: begin
          unique case (i_cls)
            CLS_R:   o_state_nxt = ST_RD_C;
            CLS_I:   o_state_nxt = ST_WAIT_RES;
            CLS_S:   o_state_nxt = ST_RD_A;
            default: o_state_nxt = ST_DONE;
          endcase
        end
        ST_RD_C:     o_state_nxt = ST_WAIT_RES;
        ST_RD_A:     o_state_nxt = ST_DONE;
        ST_WAIT_RES: if (i_res_valid) o_state_nxt = ST_WR_A;
        ST_WR_A:     o_state_nxt = ST_DONE;
        ST_DONE:     o_state_nxt = ST_IDLE;
        default:     o_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_sel    = '0;
    o_sel_en = 1'b0;
    o_sel_wr = 1'b0;
    o_busy   = (o_state_nxt != ST_IDLE);
    o_done   = (o_state_nxt == ST_DONE);
    unique case (o_state_nxt)
      ST_RD_B: begin
        o_sel    = i_rb;
        o_sel_en = 1'b1;
      end
      ST_RD_C: begin
        o_sel    = i_rc;
        o_sel_en = 1'b1;
      end
      ST_RD_A: begin
        o_sel    = i_ra;
        o_sel_en = 1'b1;
      end
      ST_WR_A: begin
        // Write-back to a hardwired R0 keeps its phase cycle but never enables the decoder
        o_sel    = i_ra;
        o_sel_wr = 1'b1;
        o_sel_en = !(R0_HARDWIRED && (i_ra == '0));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// reg_access_sequencer: latches an instruction word and steps through its
// register operand accesses (Rb, Rc, Ra), one per cycle, driving the 4-to-16
// register-select decoder. Waits for the ALU result before the Ra write-back.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       begin a sequence (sampled in IDLE)
//   ir          instruction word, latched when start is accepted
//   hold        freeze FSM and outputs
//   flush       synchronous abort back to IDLE
//   res_valid   ALU result ready
//   sel         register index to decoder
//   sel_en      decoder enable
//   sel_wr      1 = write (Rin), 0 = read (Rout)
//   busy        sequence in progress
//   done        one-cycle end-of-sequence pulse
module reg_access_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned OPC_W        = 5,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        hold,
  input  logic        flush,
  input  logic        res_valid,
  output logic [3:0]  sel,
  output logic        sel_en,
  output logic        sel_wr,
  output logic        busy,
  output logic        done
);

  state_t           r_state;
  logic [31:0]      r_ir;
  logic [REG_W-1:0] r_sel;
  logic             r_sel_en;
  logic             r_sel_wr;
  logic             r_busy;
  logic             r_done;

  logic [31:0]      w_ir_src;
  logic [OPC_W-1:0] w_opc;
  cls_t             w_cls;
  state_t           w_state_nxt;
  logic [REG_W-1:0] w_sel_nxt;
  logic             w_sel_en_nxt;
  logic             w_sel_wr_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_unused_ir;

  // In IDLE the first phase's outputs are registered on the same edge that
  // latches the IR, so the decode must look at the incoming word.
  assign w_ir_src    = (r_state == ST_IDLE) ? ir : r_ir;
  assign w_opc       = w_ir_src[OPC_MSB -: OPC_W];
  assign w_cls       = opc_class(w_opc);
  assign w_unused_ir = ^w_ir_src[RC_LSB-1:0];

  seq_next_state #(
    .R0_HARDWIRED (R0_HARDWIRED)
  ) u_next (
    .i_state     (r_state),
    .i_cls       (w_cls),
    .i_hold      (hold),
    .i_flush     (flush),
    .i_start     (start),
    .i_res_valid (res_valid),
    .i_ra        (w_ir_src[RA_LSB +: REG_W]),
    .i_rb        (w_ir_src[RB_LSB +: REG_W]),
    .i_rc        (w_ir_src[RC_LSB +: REG_W]),
    .o_state_nxt (w_state_nxt),
    .o_sel       (w_sel_nxt),
    .o_sel_en    (w_sel_en_nxt),
    .o_sel_wr    (w_sel_wr_nxt),
    .o_busy      (w_busy_nxt),
    .o_done      (w_done_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ir     <= '0;
      r_sel    <= '0;
      r_sel_en <= 1'b0;
      r_sel_wr <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_sel_en <= w_sel_en_nxt;
      r_sel_wr <= w_sel_wr_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      if (r_state == ST_IDLE && w_state_nxt != ST_IDLE)
        r_ir <= ir;
    end
  end

  assign sel    = r_sel;
  assign sel_en = r_sel_en;
  assign sel_wr = r_sel_wr;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_reg_access_sequencer.sv
module tb_reg_access_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] ir;
  logic        hold;
  logic        flush;
  logic        res_valid;
  logic [3:0]  sel;
  logic        sel_en;
  logic        sel_wr;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  reg_access_sequencer #(
    .OPC_W        (5),
    .R0_HARDWIRED (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ir        (ir),
    .hold      (hold),
    .flush     (flush),
    .res_valid (res_valid),
    .sel       (sel),
    .sel_en    (sel_en),
    .sel_wr    (sel_wr),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {busy, done, sel, sel_en, sel_wr}
  function automatic logic [7:0] outv(input logic b, input logic d, input logic [3:0] s,
                                      input logic e, input logic w);
    return {b, d, s, e, w};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'h0};
  endfunction

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {busy,done,sel,en,wr}=%b expected %b", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {busy, done, sel, sel_en, sel_wr};
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; ir = '0; hold = 1'b0; flush = 1'b0; res_valid = 1'b0;
    #1;
    check("reset", obs(), outv(0, 0, 4'd0, 0, 0));
    #12 rst_n = 1'b1;

    // R-type: Ra=3 Rb=5 Rc=7, res_valid after two WAIT cycles
    ir = mk_ir(5'b00011, 4'd3, 4'd5, 4'd7); start = 1'b1;
    tick; start = 1'b0; ir = '0;
    check("r_rdb",   obs(), outv(1, 0, 4'd5, 1, 0));
    tick; check("r_rdc",   obs(), outv(1, 0, 4'd7, 1, 0));
    tick; check("r_wait1", obs(), outv(1, 0, 4'd0, 0, 0));
    tick; check("r_wait2", obs(), outv(1, 0, 4'd0, 0, 0));
    res_valid = 1'b1;
    tick; res_valid = 1'b0;
    check("r_wra",   obs(), outv(1, 0, 4'd3, 1, 1));
    tick; check("r_done",  obs(), outv(1, 1, 4'd0, 0, 0));
    tick; check("r_idle",  obs(), outv(0, 0, 4'd0, 0, 0));

    // Store: Ra=9 Rb=2
    ir = mk_ir(5'b00010, 4'd9, 4'd2, 4'd0); start = 1'b1;
    tick; start = 1'b0;
    check("s_rdb",  obs(), outv(1, 0, 4'd2, 1, 0));
    tick; check("s_rda",  obs(), outv(1, 0, 4'd9, 1, 0));
    tick; check("s_done", obs(), outv(1, 1, 4'd0, 0, 0));
    tick; check("s_idle", obs(), outv(0, 0, 4'd0, 0, 0));

    // I-type writing R0: WR_A cycle with sel_en low
    ir = mk_ir(5'b00001, 4'd0, 4'd6, 4'd0); start = 1'b1;
    tick; start = 1'b0;
    check("i_rdb",  obs(), outv(1, 0, 4'd6, 1, 0));
    tick; check("i_wait", obs(), outv(1, 0, 4'd0, 0, 0));
    res_valid = 1'b1;
    tick; res_valid = 1'b0;
    check("i_wr_r0", obs(), outv(1, 0, 4'd0, 0, 1));
    tick; check("i_done", obs(), outv(1, 1, 4'd0, 0, 0));
    tick; check("i_idle", obs(), outv(0, 0, 4'd0, 0, 0));

    // None class, then start held through DONE: only accepted in next IDLE (branch Ra=12)
    ir = mk_ir(5'b11010, 4'd1, 4'd2, 4'd3); start = 1'b1;
    tick;
    check("n_done", obs(), outv(1, 1, 4'd0, 0, 0));
    ir = mk_ir(5'b10010, 4'd12, 4'd1, 4'd1);
    tick; check("n_no_restart", obs(), outv(0, 0, 4'd0, 0, 0));
    tick; start = 1'b0;
    check("b_rda",  obs(), outv(1, 0, 4'd12, 1, 0));
    tick; check("b_done", obs(), outv(1, 1, 4'd0, 0, 0));
    tick; check("b_idle", obs(), outv(0, 0, 4'd0, 0, 0));

    // Hold during RD_C and during WAIT_RES; start while busy is ignored
    ir = mk_ir(5'b00100, 4'd2, 4'd1, 4'd4); start = 1'b1;
    tick;
    ir = mk_ir(5'b10010, 4'd15, 4'd15, 4'd15);
    check("h_rdb", obs(), outv(1, 0, 4'd1, 1, 0));
    tick; check("h_rdc0", obs(), outv(1, 0, 4'd4, 1, 0));
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick; check("h_rdc_held", obs(), outv(1, 0, 4'd4, 1, 0));
    end
    hold = 1'b0;
    tick; check("h_wait", obs(), outv(1, 0, 4'd0, 0, 0));
    hold = 1'b1; res_valid = 1'b1;
    tick; check("h_wait_held", obs(), outv(1, 0, 4'd0, 0, 0));
    hold = 1'b0;
    tick; res_valid = 1'b0; start = 1'b0;
    check("h_wra",  obs(), outv(1, 0, 4'd2, 1, 1));
    tick; check("h_done", obs(), outv(1, 1, 4'd0, 0, 0));
    tick; check("h_idle", obs(), outv(0, 0, 4'd0, 0, 0));

    // Flush in WAIT_RES: IDLE next edge, no done pulse
    ir = mk_ir(5'b00011, 4'd3, 4'd5, 4'd7); start = 1'b1;
    tick; start = 1'b0;
    tick;
    tick; check("f_wait", obs(), outv(1, 0, 4'd0, 0, 0));
    flush = 1'b1; res_valid = 1'b1;
    tick; flush = 1'b0; res_valid = 1'b0;
    check("f_idle",    obs(), outv(0, 0, 4'd0, 0, 0));
    tick; check("f_no_done", obs(), outv(0, 0, 4'd0, 0, 0));

    // Asynchronous reset mid-RD_B
    ir = mk_ir(5'b00010, 4'd9, 4'd2, 4'd0); start = 1'b1;
    tick; start = 1'b0;
    check("a_rdb", obs(), outv(1, 0, 4'd2, 1, 0));
    #2 rst_n = 1'b0;
    #1 check("a_reset_async", obs(), outv(0, 0, 4'd0, 0, 0));
    #2 rst_n = 1'b1;
    tick; check("a_idle", obs(), outv(0, 0, 4'd0, 0, 0));

    // New start accepted afterwards (branch Ra=5)
    ir = mk_ir(5'b10010, 4'd5, 4'd0, 4'd0); start = 1'b1;
    tick; start = 1'b0;
    check("a_restart_rda", obs(), outv(1, 0, 4'd5, 1, 0));
    tick; check("a_restart_done", obs(), outv(1, 1, 4'd0, 0, 0));
    tick; check("a_restart_idle", obs(), outv(0, 0, 4'd0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
